// File: rtl/cpu_alu_pkg.sv
// Shared ALU definitions: datapath defaults, opcode map, sequencer state
// encoding and the opcode-class bundle produced by alu_op_classify.
package cpu_alu_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_AW_DEF = 4;
  localparam int unsigned OP_W       = 5;

  // Opcode map; 00000 is the idle code that makes the ALU output zero.
  localparam logic [OP_W-1:0] OP_NOP  = 5'b00000;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;

  // S_DROP is the single cycle in which an illegal instruction raises err.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ_A = 3'd1,
    S_READ_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_DROP   = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic is_legal;
    logic is_unary;
    logic is_imm;
    logic is_wide;
  } op_class_t;

endpackage

// File: rtl/alu_op_classify.sv
// Opcode classifier: maps an ALU opcode to its class flags.
// Ports:
//   op   in   OP_W        opcode to classify
//   cls  out  op_class_t  {is_legal, is_unary, is_imm, is_wide}; all 0 for illegal codes
module alu_op_classify
  import cpu_alu_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output op_class_t       cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: begin
        cls.is_legal = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        cls.is_legal = 1'b1;
        cls.is_imm   = 1'b1;
      end
      OP_NEG, OP_NOT: begin
        cls.is_legal = 1'b1;
        cls.is_unary = 1'b1;
      end
      OP_MUL, OP_DIV: begin
        cls.is_legal = 1'b1;
        cls.is_wide  = 1'b1;
      end
      default: begin
        cls = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// ALU issue sequencer: accepts one decoded instruction per handshake, reads
// its operands from the register file, drives the combinational ALU and
// writes the result to a GPR or to the HI/LO pair. One instruction in flight.
// Ports:
//   clk, clr                 clock; synchronous active-low reset
//   instr_valid/instr_ready  decoder handshake (ready only while idle)
//   instr_op/ra/rb/rc/imm    decoded instruction fields
//   rf_raddr, rf_rdata       register-file combinational read port
//   alu_opcode/alu_y/alu_b   ALU operands (B zero-extended to 2*DATA_W)
//   alu_zhi, alu_zlo         ALU results
//   rf_we/rf_waddr/rf_wdata  GPR write port, 1-cycle strobe
//   hilo_we/hi_wdata/lo_wdata HI/LO write port, 1-cycle strobe
//   done, err                retire / illegal-drop pulses
module alu_sequencer
  import cpu_alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OP_W-1:0]     instr_op,
  input  logic [REG_AW-1:0]   instr_ra,
  input  logic [REG_AW-1:0]   instr_rb,
  input  logic [REG_AW-1:0]   instr_rc,
  input  logic [DATA_W-1:0]   instr_imm,
  output logic [REG_AW-1:0]   rf_raddr,
  input  logic [DATA_W-1:0]   rf_rdata,
  output logic [OP_W-1:0]     alu_opcode,
  output logic [DATA_W-1:0]   alu_y,
  output logic [2*DATA_W-1:0] alu_b,
  input  logic [2*DATA_W-1:0] alu_zhi,
  input  logic [2*DATA_W-1:0] alu_zlo,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                hilo_we,
  output logic [DATA_W-1:0]   hi_wdata,
  output logic [DATA_W-1:0]   lo_wdata,
  output logic                done,
  output logic                err
);

  localparam int unsigned ZW = 2 * DATA_W;

  seq_state_t          state_q, state_d;
  logic [OP_W-1:0]     op_q;
  logic [REG_AW-1:0]   rb_q, rc_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   y_q, y_d;
  logic [ZW-1:0]       b_q, b_d;
  logic [DATA_W-1:0]   zhi_q;
  logic [ZW-1:0]       zlo_q;
  op_class_t           cls;
  logic                accept;

  logic                ready_d, rf_we_d, hilo_we_d, done_d, err_d;
  logic [REG_AW-1:0]   raddr_d;
  logic [OP_W-1:0]     opcode_d;

  // Only the low word of Z_hi is ever written back.
  logic unused_zhi;
  assign unused_zhi = ^alu_zhi[ZW-1:DATA_W];

  alu_op_classify u_classify (
    .op  (op_q),
    .cls (cls)
  );

  // Operand and result registers are the ALU-facing / write-back outputs.
  assign alu_y    = y_q;
  assign alu_b    = b_q;
  assign rf_waddr = rc_q;
  assign rf_wdata = zlo_q[DATA_W-1:0];
  assign hi_wdata = zlo_q[ZW-1:DATA_W];
  assign lo_wdata = zhi_q;

  // Next state, next operand values, and next values of registered outputs.
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    b_d       = b_q;
    accept    = 1'b0;
    ready_d   = 1'b0;
    raddr_d   = '0;
    opcode_d  = OP_NOP;
    rf_we_d   = 1'b0;
    hilo_we_d = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (instr_ready && instr_valid) begin
          accept  = 1'b1;
          state_d = S_READ_A;
          b_d     = '0;            // unary ops keep B = 0
        end
      end
      S_READ_A: begin
        y_d = rf_rdata;
        if (!cls.is_legal) begin
          state_d = S_DROP;
        end else if (cls.is_unary) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_READ_B;
        end
      end
      S_READ_B: begin
        b_d     = cls.is_imm ? ZW'(imm_q) : ZW'(rf_rdata);
        state_d = S_EXEC;
      end
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      S_DROP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_d)
      S_IDLE:   ready_d  = 1'b1;
      S_READ_A: raddr_d  = instr_ra;   // READ_A is only entered on accept
      S_READ_B: raddr_d  = cls.is_imm ? '0 : rb_q;
      S_EXEC:   opcode_d = op_q;
      S_WB: begin
        rf_we_d   = !cls.is_wide;
        hilo_we_d = cls.is_wide;
        done_d    = 1'b1;
      end
      S_DROP:   err_d    = 1'b1;
      default:  ready_d  = 1'b0;
    endcase
  end

  // State, instruction latch, operand/result and output registers.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NOP;
      rb_q        <= '0;
      rc_q        <= '0;
      imm_q       <= '0;
      y_q         <= '0;
      b_q         <= '0;
      zhi_q       <= '0;
      zlo_q       <= '0;
      instr_ready <= 1'b0;
      rf_raddr    <= '0;
      alu_opcode  <= OP_NOP;
      rf_we       <= 1'b0;
      hilo_we     <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= instr_op;
        rb_q  <= instr_rb;
        rc_q  <= instr_rc;
        imm_q <= instr_imm;
      end
      y_q <= y_d;
      b_q <= b_d;
      if (state_q == S_EXEC) begin
        zhi_q <= alu_zhi[DATA_W-1:0];
        zlo_q <= alu_zlo;
      end
      instr_ready <= ready_d;
      rf_raddr    <= raddr_d;
      alu_opcode  <= opcode_d;
      rf_we       <= rf_we_d;
      hilo_we     <= hilo_we_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: register file and ALU stub, directed and random
// instructions, scoreboard of expected retirements checked by a monitor.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic        instr_valid, instr_ready;
  logic [4:0]  instr_op;
  logic [3:0]  instr_ra, instr_rb, instr_rc;
  logic [31:0] instr_imm;
  logic [3:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_y;
  logic [63:0] alu_b, alu_zhi, alu_zlo;
  logic        rf_we, hilo_we, done, err;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata, hi_wdata, lo_wdata;

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  int ready_chk = -1;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;     // 0 GPR write, 1 HI/LO write, 2 dropped
    logic [4:0]  op;
    logic [31:0] y;
    logic [63:0] b;
    logic [3:0]  rb, rc;
    logic [31:0] wdata, hi, lo;
    bit          immop;
    int          acc, exec_c, fin_c;
  } exp_t;

  exp_t sbq[$];

  alu_sequencer dut (
    .clk(clk), .clr(clr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_ra(instr_ra), .instr_rb(instr_rb),
    .instr_rc(instr_rc), .instr_imm(instr_imm),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .alu_opcode(alu_opcode), .alu_y(alu_y), .alu_b(alu_b),
    .alu_zhi(alu_zhi), .alu_zlo(alu_zlo),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .done(done), .err(err)
  );

  // Architectural results of the 32-bit operations.
  function automatic logic [31:0] arith(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    case (op)
      5'b00011: return a + b;
      5'b00100: return a - b;
      5'b00101: return a >> s;
      5'b00110: return a << s;
      5'b00111: return (a >> s) | (a << (32 - s));
      5'b01000: return (a << s) | (a >> (32 - s));
      5'b01001, 5'b01100: return a & b;
      5'b01010, 5'b01101: return a | b;
      5'b10000: return 32'd0 - a;
      5'b10001: return ~a;
      default:  return 32'd0;
    endcase
  endfunction

  // {HI, LO} of the wide operations: product, or remainder/quotient.
  function automatic logic [63:0] wide(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    if (op == 5'b01110) return 64'(a) * 64'(b);
    if (op == 5'b01111) return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
    return 64'd0;
  endfunction

  // ALU stub: packs HI into Z_lo[63:32] and LO into Z_hi[31:0].
  logic [31:0] beff;
  logic [63:0] wres;
  always_comb begin
    beff = alu_b[31:0] ^ alu_b[63:32];
    wres = wide(alu_opcode, alu_y, beff);
    if (alu_opcode == 5'b01110 || alu_opcode == 5'b01111) begin
      alu_zlo = wres;
      alu_zhi = {32'd0, wres[31:0]};
    end else begin
      alu_zlo = {32'd0, arith(alu_opcode, alu_y, beff)};
      alu_zhi = 64'd0;
    end
  end

  // Register file with combinational read.
  logic [31:0] regs [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = 4'd0;
  logic [31:0] pre_data = 32'd0;
  assign rf_rdata = regs[rf_raddr];

  always @(posedge clk) begin
    if (pre_we) regs[pre_addr] <= pre_data;
    if (rf_we)  regs[rf_waddr] <= rf_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_ne(input string name, input logic [63:0] act, input logic [63:0] bad);
    n_chk++;
    if (act === bad) begin
      n_fail++;
      $display("FAIL %s: got %0h expected anything but %0h (cycle %0d)", name, act, bad, cyc);
    end
  endtask

  task automatic preload(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = addr; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Offer one instruction, push its expected outcome on acceptance, then
  // keep valid high with junk fields for 'hold' busy cycles.
  task automatic issue(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rc, input logic [31:0] imm, input int hold,
                       output int acc);
    exp_t e;
    bit legal, unary, immop, wop;
    logic [31:0] bop;
    logic [63:0] w;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = op; instr_ra = ra; instr_rb = rb;
    instr_rc = rc; instr_imm = imm;
    acc = -1;
    for (int k = 0; k < 60; k++) begin
      if (instr_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("accept_timeout", 64'(acc >= 0), 64'd1);
    if (acc < 0) begin
      instr_valid = 1'b0;
      return;
    end
    unary = (op == 5'b10000 || op == 5'b10001);
    immop = (op == 5'b01100 || op == 5'b01101);
    wop   = (op == 5'b01110 || op == 5'b01111);
    legal = unary || immop || wop || (op >= 5'b00011 && op <= 5'b01010);
    bop   = immop ? imm : (unary ? 32'd0 : regs[rb]);
    w     = wide(op, regs[ra], bop);
    e.op = op; e.y = regs[ra]; e.b = {32'd0, bop}; e.rb = rb; e.rc = rc;
    e.wdata = arith(op, regs[ra], bop); e.hi = w[63:32]; e.lo = w[31:0];
    e.immop = immop; e.acc = acc;
    if (!legal) begin
      e.kind = 2; e.exec_c = -1; e.fin_c = acc + 2;
    end else begin
      e.kind   = wop ? 1 : 0;
      e.exec_c = acc + (unary ? 2 : 3);
      e.fin_c  = acc + (unary ? 3 : 4);
    end
    sbq.push_back(e);
    @(posedge clk);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      instr_op = 5'($urandom); instr_ra = 4'($urandom); instr_rb = 4'($urandom);
      instr_rc = 4'($urandom); instr_imm = $urandom;
    end
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // Monitor: timing, ALU operands and write-back against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (sbq.size() != 0 && cyc > sbq[0].acc && cyc <= sbq[0].fin_c)
        chk("busy_ready", 64'(instr_ready), 64'd0);
      if (cyc == ready_chk)
        chk("ready_after_retire", 64'(instr_ready), 64'd1);
      if (sbq.size() != 0 && sbq[0].immop && sbq[0].rb != 0 && cyc == sbq[0].acc + 2)
        chk_ne("imm_raddr", 64'(rf_raddr), 64'(sbq[0].rb));
      if (alu_opcode != 5'd0) begin
        if (sbq.size() == 0) begin
          chk("stray_alu_op", 64'(alu_opcode), 64'd0);
        end else begin
          chk("exec_cycle", 64'(cyc), 64'(sbq[0].exec_c));
          chk("alu_opcode", 64'(alu_opcode), 64'(sbq[0].op));
          chk("alu_y", 64'(alu_y), 64'(sbq[0].y));
          chk("alu_b", alu_b, sbq[0].b);
        end
      end
      if (rf_we || hilo_we || err || done) begin
        if (sbq.size() == 0) begin
          chk("stray_strobe", 64'({rf_we, hilo_we, err, done}), 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("retire_cycle", 64'(cyc), 64'(e.fin_c));
          chk("rf_we", 64'(rf_we), 64'(e.kind == 0));
          chk("hilo_we", 64'(hilo_we), 64'(e.kind == 1));
          chk("err", 64'(err), 64'(e.kind == 2));
          chk("done", 64'(done), 64'(e.kind != 2));
          if (e.kind == 0) begin
            chk("rf_waddr", 64'(rf_waddr), 64'(e.rc));
            chk("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
          end
          if (e.kind == 1) begin
            chk("hi_wdata", 64'(hi_wdata), 64'(e.hi));
            chk("lo_wdata", 64'(lo_wdata), 64'(e.lo));
          end
          ready_chk = cyc + 1;
        end
      end
    end
  end

  initial begin
    int acc;
    logic [4:0] legal_ops [14];
    legal_ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                  5'b01010, 5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b10000, 5'b10001};
    clr = 1'b0; instr_valid = 1'b0; instr_op = '0; instr_ra = '0; instr_rb = '0;
    instr_rc = '0; instr_imm = '0;

    // Reset, filling the register file meanwhile.
    for (int i = 0; i < 16; i++) preload(4'(i), $urandom);
    chk("rst_ready", 64'(instr_ready), 64'd0);
    chk("rst_strobes", 64'({rf_we, hilo_we, done, err}), 64'd0);
    chk("rst_alu_opcode", 64'(alu_opcode), 64'd0);
    chk("rst_raddr", 64'(rf_raddr), 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    clr = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(instr_ready), 64'd1);
    mon_en = 1'b1;

    // Directed cases.
    preload(4'd1, 32'd5); preload(4'd2, 32'd7);
    issue(5'b00011, 4'd1, 4'd2, 4'd3, 32'd0, 1, acc);               // add -> 12
    preload(4'd1, 32'h0001_0000); preload(4'd2, 32'h0001_0000);
    issue(5'b01110, 4'd1, 4'd2, 4'd7, 32'd0, 2, acc);               // mul -> HI=1 LO=0
    preload(4'd1, 32'hFFFF_00FF); preload(4'd6, 32'h1234_5678);
    issue(5'b01100, 4'd1, 4'd6, 4'd8, 32'h0000_0F0F, 0, acc);       // andi -> 0xF
    preload(4'd4, 32'd1);
    issue(5'b10000, 4'd4, 4'd9, 4'd5, 32'd0, 2, acc);               // neg -> all ones
    issue(5'b11111, 4'd2, 4'd3, 4'd4, 32'd0, 2, acc);               // illegal
    issue(5'b01111, 4'd1, 4'd0, 4'd0, 32'd0, 0, acc);               // div by random R0

    // Randomized instructions, mostly legal.
    for (int i = 0; i < 40; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom) : legal_ops[$urandom_range(0, 13)];
      issue(op, 4'($urandom), 4'($urandom), 4'($urandom), $urandom,
            int'($urandom_range(0, 2)), acc);
    end
    for (int k = 0; k < 50 && sbq.size() != 0; k++) @(negedge clk);
    chk("drain", 64'(sbq.size()), 64'd0);

    // Reset during EXEC of an add: no write, ready right after release.
    preload(4'd1, 32'd5); preload(4'd2, 32'd7); preload(4'd3, 32'hDEAD_BEEF);
    issue(5'b00011, 4'd1, 4'd2, 4'd3, 32'd0, 0, acc);
    while (cyc < acc + 2) @(negedge clk);
    mon_en = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("rst_exec_opcode", 64'(alu_opcode), 64'h3);
    clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_rst_strobes", 64'({rf_we, hilo_we, done, err}), 64'd0);
      chk("mid_rst_ready", 64'(instr_ready), 64'd0);
    end
    clr = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 64'(instr_ready), 64'd1);
    chk("no_write_after_rst", 64'(regs[3]), 64'hDEAD_BEEF);
    ready_chk = -1;
    mon_en = 1'b1;

    // Back to normal operation after the mid-flight reset.
    issue(5'b01010, 4'd1, 4'd2, 4'd10, 32'd0, 1, acc);
    for (int k = 0; k < 50 && sbq.size() != 0; k++) @(negedge clk);
    chk("drain_final", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
